cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
- Controller that shares one subtractor/flag unit and the signed/unsigned less-than comparator between two requesters, e.g. the CPU branch/SLT path and the maze-generator bounds checker.
- Each request is one comparison: operands A and B plus a signedness select.
- The block grants one requester round-robin, drives the shared subtractor, and waits for the flags to settle.
- It then returns the registered less-than result with a done pulse.

Parameters:
- W, 32, operand width in bits.
- LAT, 1, cycles from sub_en until FlagN/FlagV/FlagC are valid at the ALU. Legal range 1..15.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held high until gnt0.
- a0  in  W  requester 0 operand A.
- b0  in  W  requester 0 operand B.
- uns0  in  1  requester 0 compare select: 1 = unsigned, 0 = signed.
- req1, a1, b1, uns1  in  1/W/W/1  same as above for requester 1.
- gnt0, gnt1  out  1  one-cycle grant; operands are captured in this cycle.
- done0, done1  out  1  one-cycle result-valid pulse.
- lt0, lt1  out  1  less-than result (A<B); held until that requester's next done.
- busy  out  1  high in every state other than IDLE.
- sub_a, sub_b  out  W  operands to the shared subtractor (A-B).
- sub_en  out  1  subtractor issue strobe.
- bool0  out  1  comparator select: 1 = unsigned (uses ~C), 0 = signed (uses N^V).
- FlagN, FlagV, FlagC  in  1  flags from the shared subtractor.
- comparison  in  1  comparator output.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE. gnt*, done*, lt*, busy, sub_en, bool0 = 0. sub_a = sub_b = 0. Priority pointer favours requester 0.
- FSM states: IDLE -> ISSUE -> WAIT -> CAPT -> IDLE.
- IDLE:
  - If any req is high, assert the chosen gnt combinationally.
  - Capture that requester's a/b/uns into the op registers and record the owner id.
  - Go to ISSUE.
  - If no req is high, stay in IDLE.
- Arbitration: round-robin. If both req are high, the requester not granted last wins. If only one is high, it wins regardless of the pointer. The pointer updates at grant.
- ISSUE: sub_en=1 for exactly one cycle. sub_a/sub_b/bool0 are driven from the op registers. Load the wait counter with LAT-1 and go to WAIT.
- WAIT: hold sub_a/sub_b/bool0. Decrement the counter. When it reaches 0, go to CAPT. WAIT lasts exactly LAT cycles.
- CAPT:
  - Register lt_owner <= comparison and done_owner <= 1.
  - The done and updated lt become visible the next cycle; the FSM is in IDLE that cycle.
  - The other requester's lt is unchanged.
- Timing, request seen at cycle c0 in IDLE:
  - gnt at c0, sub_en at c1, CAPT at c1+LAT+1, done at c3+LAT.
  - LAT=1: done at c4.
  - Back-to-back throughput: one op per 3+LAT cycles. The IDLE cycle coincident with done may grant a new request.
- sub_a/sub_b/bool0 hold their last values in IDLE. They change only on ISSUE entry.
- Requester protocol:
  - Raise req and hold operands until gnt.
  - Deassert req in the cycle after gnt, unless issuing a new request.
  - A req still high in the done cycle is a new request.
  - Dropping req after gnt has no effect; the captured op completes and done still pulses.
- gnt0 and gnt1 are never high together. done0 and done1 are never high together.
- Reset mid-operation: abort immediately to IDLE. No done is pulsed for the aborted op, and lt* clear to 0.
- Owner-id width is 1 bit. The wait counter is 4 bits.

Test Plan:
- Signed compare, bench ALU model with LAT=1. req0 with a0=0xFFFFFFFD (-3), b0=2, uns0=0 at c0:
  - gnt0 at c0, sub_en at c1, bool0=0.
  - done0=1 and lt0=1 at c4; busy high c1..c3.
- Unsigned compare. req1 with a1=0xFFFFFFFD, b1=2, uns1=1:
  - bool0=1.
  - done1 with lt1=0, three cycles after sub_en.
  - lt0 is unchanged.
- Simultaneous requests. req0 and req1 both held continuously:
  - Grants alternate gnt0, gnt1, gnt0, gnt1.
  - Grants are spaced 4 cycles apart (LAT=1).
  - Each done goes to the matching owner.
- Latency parameter. LAT=5, a0=7, b0=7, uns0=0:
  - sub_en at c1, done0 at c8, lt0=0.
  - sub_a/sub_b are stable c1..c7.
- Reset mid-op. Assert RST in the WAIT state:
  - Next cycle: busy=0, lt0=lt1=0, and no done pulse.
  - A new req1 afterwards completes normally.
- Lone requester after the other was last granted. gnt0 previously, then only req0 high:
  - gnt0 is still issued.

Source files
------------

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin access controller for one shared subtractor and
// less-than comparator. Each granted request is issued to the subtractor,
// held for LAT settle cycles, and the comparator result is registered back
// to the owning requester together with a one-cycle done pulse.
module cmp_arbiter #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         uns0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         uns1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         lt0,
  output logic         lt1,
  output logic         busy,
  output logic [W-1:0] sub_a,
  output logic [W-1:0] sub_b,
  output logic         sub_en,
  output logic         bool0,
  input  logic         FlagN,
  input  logic         FlagV,
  input  logic         FlagC,
  input  logic         comparison
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CAPT  = 2'd3
  } state_t;

  // Counter preload so that WAIT spans exactly LAT cycles (counts LAT-1 .. 0).
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic         r_last;     // id granted most recently; 1 after reset so requester 0 wins a tie
  logic         r_owner;    // id of the operation in flight
  logic [W-1:0] r_sub_a;
  logic [W-1:0] r_sub_b;
  logic         r_bool0;
  logic         r_sub_en;
  logic         r_busy;
  logic         r_done0;
  logic         r_done1;
  logic         r_lt0;
  logic         r_lt1;
  logic         w_grant;
  logic         w_win;

  // The flags are consumed by the external comparator; only its result is used here.
  logic w_unused_flags;
  assign w_unused_flags = FlagN ^ FlagV ^ FlagC;

  // Round-robin arbitration, only while idle: a lone requester always wins,
  // on a tie the requester not granted last wins.
  always_comb begin
    w_grant = 1'b0;
    w_win   = 1'b0;
    if (r_state == S_IDLE) begin
      if (req0 && req1) begin
        w_grant = 1'b1;
        w_win   = ~r_last;
      end else if (req0) begin
        w_grant = 1'b1;
        w_win   = 1'b0;
      end else if (req1) begin
        w_grant = 1'b1;
        w_win   = 1'b1;
      end else begin
        w_grant = 1'b0;
        w_win   = 1'b0;
      end
    end else begin
      w_grant = 1'b0;
      w_win   = 1'b0;
    end
  end

  // Next-state and wait-counter logic for IDLE -> ISSUE -> WAIT -> CAPT -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = LAT_M1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_CAPT;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_state_nxt = S_WAIT;
        end
      end
      S_CAPT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, wait counter and registered busy / issue strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_sub_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_sub_en <= (w_state_nxt == S_ISSUE);
    end
  end

  // Operand capture at grant; these registers drive the subtractor directly,
  // so sub_a/sub_b/bool0 only change on entry to ISSUE and hold otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_sub_a <= {W{1'b0}};
      r_sub_b <= {W{1'b0}};
      r_bool0 <= 1'b0;
    end else if (w_grant) begin
      r_last  <= w_win;
      r_owner <= w_win;
      r_sub_a <= w_win ? a1 : a0;
      r_sub_b <= w_win ? b1 : b0;
      r_bool0 <= w_win ? uns1 : uns0;
    end else begin
      r_last  <= r_last;
      r_owner <= r_owner;
      r_sub_a <= r_sub_a;
      r_sub_b <= r_sub_b;
      r_bool0 <= r_bool0;
    end
  end

  // Result capture in CAPT: only the owner's lt moves, done pulses one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_lt0   <= 1'b0;
      r_lt1   <= 1'b0;
    end else begin
      r_done0 <= (r_state == S_CAPT) && !r_owner;
      r_done1 <= (r_state == S_CAPT) && r_owner;
      if ((r_state == S_CAPT) && !r_owner) begin
        r_lt0 <= comparison;
      end else begin
        r_lt0 <= r_lt0;
      end
      if ((r_state == S_CAPT) && r_owner) begin
        r_lt1 <= comparison;
      end else begin
        r_lt1 <= r_lt1;
      end
    end
  end

  assign gnt0   = w_grant && !w_win;
  assign gnt1   = w_grant && w_win;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign lt0    = r_lt0;
  assign lt1    = r_lt1;
  assign busy   = r_busy;
  assign sub_a  = r_sub_a;
  assign sub_b  = r_sub_b;
  assign sub_en = r_sub_en;
  assign bool0  = r_bool0;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: two instances (LAT=1 and LAT=5), each with a
// behavioural subtractor/comparator model. A cycle driver predicts grants,
// busy, issue strobe and subtractor operands from an arithmetic model and
// pushes expected results into a scoreboard; per-instance monitors pop and
// compare whenever a done pulse appears.
module tb_cmp_arbiter;
  localparam int W = 32;

  typedef struct {
    int   inst;
    logic owner;
    logic lt;
    int   cyc;
  } exp_t;

  logic         CLK;
  int           cyc;
  int           n_chk;
  int           n_fail;
  bit           mon_en;
  int           rst_at [2];

  logic         rst_s  [2];
  logic         req0_s [2];
  logic         req1_s [2];
  logic         uns0_s [2];
  logic         uns1_s [2];
  logic [W-1:0] a0_s   [2];
  logic [W-1:0] b0_s   [2];
  logic [W-1:0] a1_s   [2];
  logic [W-1:0] b1_s   [2];
  logic         gnt0_w [2];
  logic         gnt1_w [2];
  logic         done0_w[2];
  logic         done1_w[2];
  logic         lt0_w  [2];
  logic         lt1_w  [2];
  logic         busy_w [2];
  logic         sub_en_w[2];
  logic         bool0_w[2];
  logic [W-1:0] sub_a_w[2];
  logic [W-1:0] sub_b_w[2];

  exp_t         sb_q[$];

  // Reference model state (one instance is exercised at a time).
  bit           pv [2];
  logic [W-1:0] pa [2];
  logic [W-1:0] pb [2];
  logic         pu [2];
  int           last_win;
  int           next_free;
  int           gcyc;
  int           sub_cyc;
  logic [W-1:0] exp_a, exp_b, nxt_a, nxt_b;
  logic         exp_u, nxt_u;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 5;
  endfunction

  function automatic logic lt_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    if (u) return a < b;
    else   return $signed(a) < $signed(b);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LATG = (g == 0) ? 1 : 5;
    logic         fn, fv, fc, cmpv;
    logic [W:0]   sum;
    int           age;
    logic         lm0, lm1;

    cmp_arbiter #(.W(W), .LAT(LATG)) u_dut (
      .CLK(CLK), .RST(rst_s[g]),
      .req0(req0_s[g]), .a0(a0_s[g]), .b0(b0_s[g]), .uns0(uns0_s[g]),
      .req1(req1_s[g]), .a1(a1_s[g]), .b1(b1_s[g]), .uns1(uns1_s[g]),
      .gnt0(gnt0_w[g]), .gnt1(gnt1_w[g]),
      .done0(done0_w[g]), .done1(done1_w[g]),
      .lt0(lt0_w[g]), .lt1(lt1_w[g]), .busy(busy_w[g]),
      .sub_a(sub_a_w[g]), .sub_b(sub_b_w[g]), .sub_en(sub_en_w[g]), .bool0(bool0_w[g]),
      .FlagN(fn), .FlagV(fv), .FlagC(fc), .comparison(cmpv)
    );

    // Cycles since the last issue strobe; results are only valid once age >= LAT.
    always @(posedge CLK) begin
      if (rst_s[g]) age <= 100;
      else if (sub_en_w[g]) age <= 1;
      else if (age < 100) age <= age + 1;
    end

    // Shared subtractor and comparator; outputs inverted while still settling.
    always_comb begin
      sum  = {1'b0, sub_a_w[g]} + {1'b0, ~sub_b_w[g]} + {{W{1'b0}}, 1'b1};
      fn   = sum[W-1];
      fc   = sum[W];
      fv   = (sub_a_w[g][W-1] != sub_b_w[g][W-1]) && (sum[W-1] != sub_a_w[g][W-1]);
      cmpv = bool0_w[g] ? ~fc : (fn ^ fv);
      if (age < LATG) begin
        fn   = ~fn;
        fv   = ~fv;
        fc   = ~fc;
        cmpv = ~cmpv;
      end
    end

    // Monitor: pop the scoreboard on every done pulse, track held lt values.
    initial begin
      exp_t e;
      lm0 = 1'b0;
      lm1 = 1'b0;
      forever begin
        @(negedge CLK);
        #2;
        if (mon_en) begin
          if (cyc == rst_at[g] + 1) begin
            lm0 = 1'b0;
            lm1 = 1'b0;
          end
          if (done0_w[g] || done1_w[g]) begin
            chk("done_excl", 32'(done0_w[g] & done1_w[g]), 32'd0);
            if (sb_q.size() == 0) begin
              chk("done_unexpected", 32'({done0_w[g], done1_w[g]}), 32'd0);
            end else begin
              e = sb_q.pop_front();
              chk("done_inst", 32'(g), 32'(e.inst));
              chk("done_owner", 32'(done1_w[g]), 32'(e.owner));
              chk("done_cycle", 32'(cyc), 32'(e.cyc));
              if (done1_w[g]) lm1 = e.lt;
              else            lm0 = e.lt;
            end
          end else if (sb_q.size() > 0 && sb_q[0].inst == g && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            chk("done_missing", 32'({done0_w[g], done1_w[g]}), e.owner ? 32'd1 : 32'd2);
            if (e.owner) lm1 = e.lt;
            else         lm0 = e.lt;
          end
          chk("lt0", 32'(lt0_w[g]), 32'(lm0));
          chk("lt1", 32'(lt1_w[g]), 32'(lm1));
        end
      end
    end
  end

  task automatic model_init();
    pv[0] = 1'b0; pv[1] = 1'b0;
    last_win  = 1;
    next_free = cyc;
    gcyc      = -1000;
    sub_cyc   = -1;
    exp_a = '0; exp_b = '0; exp_u = 1'b0;
    nxt_a = '0; nxt_b = '0; nxt_u = 1'b0;
  endtask

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    pv[r] = 1'b1; pa[r] = a; pb[r] = b; pu[r] = u;
  endtask

  task automatic new_op(input int r);
    int sel;
    sel   = $urandom_range(0, 3);
    pa[r] = $urandom();
    case (sel)
      0:       pb[r] = pa[r];
      1:       pb[r] = pa[r] ^ 32'h8000_0000;
      2:       pb[r] = pa[r] + 32'd1;
      default: pb[r] = $urandom();
    endcase
    pu[r] = 1'($urandom_range(0, 1));
    pv[r] = 1'b1;
  endtask

  // One clock cycle on instance k: drive, check against model, advance model.
  task automatic step(input int k, input logic rst);
    int win;
    int lat;
    lat = lat_of(k);
    @(negedge CLK);
    if (cyc == sub_cyc) begin
      exp_a = nxt_a; exp_b = nxt_b; exp_u = nxt_u;
    end
    rst_s[k]  = rst;
    req0_s[k] = pv[0];
    req1_s[k] = pv[1];
    a0_s[k]   = pv[0] ? pa[0] : $urandom();
    b0_s[k]   = pv[0] ? pb[0] : $urandom();
    uns0_s[k] = pv[0] ? pu[0] : 1'($urandom_range(0, 1));
    a1_s[k]   = pv[1] ? pa[1] : $urandom();
    b1_s[k]   = pv[1] ? pb[1] : $urandom();
    uns1_s[k] = pv[1] ? pu[1] : 1'($urandom_range(0, 1));
    #1;
    win = -1;
    if (!rst && cyc >= next_free) begin
      if (pv[0] && pv[1]) win = 1 - last_win;
      else if (pv[0])     win = 0;
      else if (pv[1])     win = 1;
    end
    chk("gnt0", 32'(gnt0_w[k]), 32'(win == 0));
    chk("gnt1", 32'(gnt1_w[k]), 32'(win == 1));
    chk("busy", 32'(busy_w[k]), 32'((cyc > gcyc) && (cyc < next_free)));
    chk("sub_en", 32'(sub_en_w[k]), 32'(cyc == gcyc + 1));
    chk("sub_a", sub_a_w[k], exp_a);
    chk("sub_b", sub_b_w[k], exp_b);
    chk("bool0", 32'(bool0_w[k]), 32'(exp_u));
    if (win >= 0) begin
      sb_q.push_back('{k, 1'(win), lt_ref(pa[win], pb[win], pu[win]), cyc + 3 + lat});
      next_free = cyc + 3 + lat;
      gcyc      = cyc;
      last_win  = win;
      sub_cyc   = cyc + 1;
      nxt_a = pa[win]; nxt_b = pb[win]; nxt_u = pu[win];
      pv[win] = 1'b0;
    end
    if (rst) begin
      sb_q.delete();
      pv[0] = 1'b0; pv[1] = 1'b0;
      last_win  = 1;
      next_free = cyc + 1;
      gcyc      = -1000;
      sub_cyc   = cyc + 1;
      nxt_a = '0; nxt_b = '0; nxt_u = 1'b0;
      rst_at[k] = cyc;
    end
  endtask

  task automatic run(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 80 && (sb_q.size() > 0 || pv[0] || pv[1]); i++) step(k, 1'b0);
    run(k, 2);
  endtask

  task automatic random_phase(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 3) == 0) new_op(r);
      end
      step(k, 1'b0);
    end
    drain(k);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; mon_en = 1'b0;
    rst_at[0] = -1000; rst_at[1] = -1000;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; req0_s[k] = 1'b0; req1_s[k] = 1'b0;
      uns0_s[k] = 1'b0; uns1_s[k] = 1'b0;
      a0_s[k] = '0; b0_s[k] = '0; a1_s[k] = '0; b1_s[k] = '0;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    model_init();
    mon_en = 1'b1;

    // LAT=1 instance: reset state, then directed cases.
    run(0, 3);
    set_op(0, 32'hFFFF_FFFD, 32'd2, 1'b0);
    run(0, 6);
    set_op(1, 32'hFFFF_FFFD, 32'd2, 1'b1);
    run(0, 6);
    for (int i = 0; i < 16; i++) begin
      if (!pv[0]) new_op(0);
      if (!pv[1]) new_op(1);
      step(0, 1'b0);
    end
    drain(0);
    set_op(0, 32'd3, 32'd4, 1'b0);
    run(0, 5);
    set_op(0, 32'h8000_0000, 32'd1, 1'b1);
    run(0, 5);
    set_op(1, 32'd5, 32'd9, 1'b0);
    step(0, 1'b0);
    step(0, 1'b0);
    step(0, 1'b1);
    run(0, 2);
    set_op(1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run(0, 6);
    random_phase(0, 300);

    // LAT=5 instance.
    model_init();
    set_op(0, 32'd7, 32'd7, 1'b0);
    run(1, 10);
    random_phase(1, 150);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
